// File: rtl/synapse_accum.sv
// synapse_accum: integrates presynaptic spikes through signed weights into a
// decaying, saturating 8-bit current feeding the lif neuron.
module synapse_accum #(
    parameter int N_IN        = 4,
    parameter int DECAY_SHIFT = 2,
    localparam int AW = (N_IN > 1) ? $clog2(N_IN) : 1,
    localparam int SW = 8 + $clog2(N_IN) + 1,
    localparam int RW = SW + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [N_IN-1:0] spike_in,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [7:0]      wr_data,
    output logic [7:0]      current,
    output logic            sat_hi,
    output logic            sat_lo
);
    logic [7:0]    weight [N_IN];
    logic [SW-1:0] sum;
    logic [7:0]    decayed;
    logic [RW-1:0] raw;
    logic          neg;
    logic          over;

    // Out-of-range addresses never match any index, so they write nothing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_IN; i++) weight[i] <= '0;
        end else begin
            for (int i = 0; i < N_IN; i++)
                if (wr_en && wr_addr == AW'(i)) weight[i] <= wr_data;
        end
    end

    always_comb begin
        sum = '0;
        for (int i = 0; i < N_IN; i++)
            if (spike_in[i]) sum = sum + {{(SW-8){weight[i][7]}}, weight[i]};
    end

    // One extra bit over the sum covers decayed (up to 255) plus the widest sum.
    assign decayed = current - (current >> DECAY_SHIFT);
    assign raw     = {{(RW-8){1'b0}}, decayed} + {sum[SW-1], sum};
    assign neg     = raw[RW-1];
    assign over    = !neg && |raw[RW-2:8];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            current <= '0;
            sat_hi  <= 1'b0;
            sat_lo  <= 1'b0;
        end else if (en) begin
            current <= neg ? 8'd0 : over ? 8'd255 : raw[7:0];
            sat_hi  <= over;
            sat_lo  <= neg;
        end else begin
            sat_hi  <= 1'b0;
            sat_lo  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_synapse_accum.sv
// tb_synapse_accum: directed vector table plus hand sequences for reset,
// collision and out-of-range write behaviour.
module tb_synapse_accum;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [3:0] spike_in = '0;
    logic       wr_en = 1'b0;
    logic [1:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic [7:0] current;
    logic       sat_hi, sat_lo;

    logic       en3 = 1'b0;
    logic [2:0] spike3 = '0;
    logic       wr_en3 = 1'b0;
    logic [1:0] wr_addr3 = '0;
    logic [7:0] wr_data3 = '0;
    logic [7:0] current3;
    logic       sat_hi3, sat_lo3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    synapse_accum #(.N_IN(4), .DECAY_SHIFT(2)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .spike_in(spike_in),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .current(current), .sat_hi(sat_hi), .sat_lo(sat_lo)
    );

    synapse_accum #(.N_IN(3), .DECAY_SHIFT(2)) dut3 (
        .clk(clk), .rst_n(rst_n), .en(en3), .spike_in(spike3),
        .wr_en(wr_en3), .wr_addr(wr_addr3), .wr_data(wr_data3),
        .current(current3), .sat_hi(sat_hi3), .sat_lo(sat_lo3)
    );

    typedef struct {
        logic       we;
        logic [1:0] wa;
        logic [7:0] wd;
        logic       en;
        logic [3:0] sp;
        logic [7:0] cur;
        logic       hi;
        logic       lo;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic we, logic [1:0] wa, logic [7:0] wd, logic e,
                                logic [3:0] sp, logic [7:0] cur, logic hi, logic lo);
        vec_t v;
        v.we = we; v.wa = wa; v.wd = wd; v.en = e; v.sp = sp;
        v.cur = cur; v.hi = hi; v.lo = lo;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic check_out(input string name, input logic [7:0] cur, input logic hi, input logic lo);
        check({name, " current"}, int'(current), int'(cur));
        check({name, " sat_hi"}, int'(sat_hi), int'(hi));
        check({name, " sat_lo"}, int'(sat_lo), int'(lo));
    endtask

    task automatic drive(input logic we, input logic [1:0] wa, input logic [7:0] wd,
                         input logic e, input logic [3:0] sp);
        @(negedge clk);
        wr_en = we; wr_addr = wa; wr_data = wd; en = e; spike_in = sp;
        @(posedge clk);
        #1;
    endtask

    int decay_seq [12] = '{30, 23, 18, 14, 11, 9, 7, 6, 5, 4, 3, 3};

    initial begin
        vecs.push_back(mk(1, 0, 8'd40, 1, 4'b0000, 0, 0, 0));
        vecs.push_back(mk(0, 0, 8'd0, 1, 4'b0001, 40, 0, 0));
        foreach (decay_seq[i]) vecs.push_back(mk(0, 0, 8'd0, 1, 4'b0000, 8'(decay_seq[i]), 0, 0));
        vecs.push_back(mk(1, 1, 8'h80, 1, 4'b0000, 3, 0, 0));
        vecs.push_back(mk(0, 0, 8'd0, 1, 4'b0010, 0, 0, 1));
        vecs.push_back(mk(1, 0, 8'd100, 1, 4'b0000, 0, 0, 0));
        vecs.push_back(mk(1, 1, 8'd100, 1, 4'b0000, 0, 0, 0));
        vecs.push_back(mk(1, 2, 8'd100, 1, 4'b0000, 0, 0, 0));
        vecs.push_back(mk(1, 3, 8'd100, 1, 4'b0000, 0, 0, 0));
        vecs.push_back(mk(0, 0, 8'd0, 1, 4'b1111, 255, 1, 0));
        vecs.push_back(mk(0, 0, 8'd0, 1, 4'b0000, 192, 0, 0));
        vecs.push_back(mk(1, 0, 8'd40, 1, 4'b0000, 144, 0, 0));
        vecs.push_back(mk(1, 1, 8'h80, 1, 4'b0000, 108, 0, 0));
        vecs.push_back(mk(0, 0, 8'd0, 1, 4'b0010, 0, 0, 1));
        vecs.push_back(mk(0, 0, 8'd0, 1, 4'b0001, 40, 0, 0));
        vecs.push_back(mk(0, 0, 8'd0, 1, 4'b0010, 0, 0, 1));
        vecs.push_back(mk(1, 2, 8'd0, 1, 4'b0000, 0, 0, 0));
        vecs.push_back(mk(0, 0, 8'd0, 1, 4'b0001, 40, 0, 0));
        vecs.push_back(mk(1, 2, 8'd50, 1, 4'b0100, 30, 0, 0));
        vecs.push_back(mk(0, 0, 8'd0, 1, 4'b0100, 73, 0, 0));
        vecs.push_back(mk(0, 0, 8'd0, 1, 4'b0010, 0, 0, 1));
        vecs.push_back(mk(0, 0, 8'd0, 1, 4'b1000, 100, 0, 0));
        vecs.push_back(mk(1, 0, 8'd7, 0, 4'b1111, 100, 0, 0));
        for (int i = 0; i < 4; i++) vecs.push_back(mk(0, 0, 8'd0, 0, 4'b1111, 100, 0, 0));
        vecs.push_back(mk(0, 0, 8'd0, 1, 4'b0000, 75, 0, 0));
        vecs.push_back(mk(0, 0, 8'd0, 1, 4'b0001, 64, 0, 0));
        vecs.push_back(mk(0, 0, 8'd0, 1, 4'b1111, 77, 0, 0));

        // Reset state, then a mid-cycle async reset with no clock edge.
        #2;
        check_out("reset", 8'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 0, 8'd40, 1, 4'b0000);
        drive(0, 0, 8'd0, 1, 4'b0001);
        check_out("pre_reset", 8'd40, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_out("async_reset", 8'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, 8'd0, 1, 4'b1111);
        check_out("weights_cleared", 8'd0, 1'b0, 1'b0);

        foreach (vecs[i]) begin
            drive(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].en, vecs[i].sp);
            check_out($sformatf("vec%0d", i), vecs[i].cur, vecs[i].hi, vecs[i].lo);
        end

        // N_IN=3: address 3 is out of range and must leave every weight unchanged.
        @(negedge clk);
        en = 1'b0; spike_in = '0; wr_en = 1'b0;
        en3 = 1'b1; wr_en3 = 1'b1;
        wr_addr3 = 2'd0; wr_data3 = 8'd10;
        @(negedge clk);
        wr_addr3 = 2'd1; wr_data3 = 8'd20;
        @(negedge clk);
        wr_addr3 = 2'd2; wr_data3 = 8'd30;
        @(negedge clk);
        wr_addr3 = 2'd3; wr_data3 = 8'd100;
        @(negedge clk);
        check("oor_idle current3", int'(current3), 0);
        wr_en3 = 1'b0; spike3 = 3'b111;
        @(negedge clk);
        spike3 = 3'b000;
        check("oor current3", int'(current3), 60);
        check("oor sat_hi3", int'(sat_hi3), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/synapse_accum.md
# synapse_accum

Upstream synaptic-current stage for the `lif` neuron. Integrates up to N_IN presynaptic spike lines through programmable signed weights into an exponentially decaying 8-bit current. Its registered `current` output drives the neuron's `current` input directly. Saturates at 0 and 255 and flags both saturation events.

## Interface
Parameters:
- N_IN, 4, number of presynaptic spike inputs (1..16)
- DECAY_SHIFT, 2, decay factor: each enabled cycle removes current>>DECAY_SHIFT (0..7; 0 = memoryless)

Ports:
- clk  in  1  single clock; all state updates on posedge
- rst_n  in  1  reset, asynchronous, active-low
- en  in  1  update enable; low = hold current, flags forced 0
- spike_in  in  N_IN  presynaptic spikes, sampled each posedge
- wr_en  in  1  weight write strobe
- wr_addr  in  clog2(N_IN) (min 1)  weight index
- wr_data  in  8  weight, signed two's complement (-128..127)
- current  out  8  unsigned synaptic current, registered, to neuron
- sat_hi  out  1  registered: last update clamped at 255
- sat_lo  out  1  registered: last update clamped at 0

## Operation
- Weight file: N_IN x 8-bit signed registers, all 0 at reset.
  - wr_en=1 writes wr_data to weight[wr_addr] at posedge.
  - Writes are independent of en.
  - wr_addr >= N_IN: write ignored, no side effect.
- Update when en=1, computed from register values before the edge:
  - sum = signed sum of weight[i] for every i with spike_in[i]=1. Width 8+clog2(N_IN)+1 bits, sign-extended; no intermediate overflow.
  - decayed = current - (current >> DECAY_SHIFT), unsigned 8-bit. Never underflows.
  - Small values do not decay to 0 for DECAY_SHIFT>=1; e.g. 3 stays 3 at shift 2. This is required behaviour.
  - raw = decayed + sum, signed, wide.
  - raw > 255: current <= 255, sat_hi <= 1.
  - raw < 0: current <= 0, sat_lo <= 1.
  - Otherwise current <= raw, both flags <= 0.
- en=0: current holds; sat_hi and sat_lo <= 0; spike_in is ignored (spikes are dropped, not queued).
- Simultaneous write and spike on the same index: the old weight is used this cycle; the new weight applies from the next cycle.
- No spikes and en=1: pure decay.

## Timing
- Async reset, asserted: immediately, without a clock, current=0, sat_hi=0, sat_lo=0, all weights=0.
  - Mid-operation reset discards the accumulated current and all weights.
- Reset deassertion takes effect at the next posedge. The first update uses spike_in at that edge.
- Latency is 1 cycle. spike_in sampled at edge k is reflected in current immediately after edge k. The neuron sees it on edge k+1.
- sat_hi and sat_lo are single-cycle-per-update: aligned with the current value they describe and valid for exactly that cycle.
- No handshakes. spike_in must be synchronous to clk.

## Test plan
All scenarios use N_IN=4, DECAY_SHIFT=2.
1. Reset and idle: assert rst_n=0 mid-cycle -> current=0, sat_hi=sat_lo=0 with no clock edge. Release, then drive spike_in=4'b1111 with no writes -> current stays 0.
2. Single weight and decay: write weight[0]=40; pulse spike_in=4'b0001 for 1 cycle.
   - current=40 after that edge.
   - Then 30, 23, 18, 14, 11, 9, 7, 6, 5, 4, 3, 3 (holds at 3).
3. High saturation: weights 0..3 = 100; spike_in=4'b1111 from current=0 -> current=255, sat_hi=1 that cycle. Next idle cycle: current=192, sat_hi=0.
4. Inhibition: from current=40, weight[1]=-128 (8'h80), spike_in=4'b0010 -> raw=30-128<0, current=0, sat_lo=1.
5. Write/spike collision:
   - weight[2]=0; write weight[2]=50 in the same cycle as spike_in[2]=1 -> current unchanged by the spike.
   - Spike again the next cycle -> +50.
   - Also write wr_addr=5 when clog2 width permits; for N_IN=4, test out-of-range via N_IN=3 -> no weight changes.
6. Enable hold: current=100, en=0 for 5 cycles with spike_in=4'b1111 -> current stays 100, flags 0. en=1 with no spikes -> 75.
